// File: rtl/avmm_pipeline_bridge.sv
// Avalon-MM pipeline bridge: fully registered command path (output reg + 1-entry skid), response path and s0_waitrequest.
// Latency: command 1 cycle s0->m0, response 1 cycle m0->s0.
// Backpressure: m0_waitrequest stalls the output reg; one more command lands in skid, then s0_waitrequest rises (registered).
//
// Ports:
//   clk, reset_n          single clock, asynchronous active-low reset
//   s0_*                  slave side facing the AFU (commands in, read responses out)
//   m0_*                  master side facing the memory model (commands out, read responses in)
module avmm_pipeline_bridge #(
    parameter int DATA_WIDTH       = 512,
    parameter int HDL_ADDR_WIDTH   = 27,
    parameter int BURSTCOUNT_WIDTH = 7,
    parameter int BYTEENABLE_WIDTH = DATA_WIDTH / 8,
    parameter int RESPONSE_WIDTH   = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    // slave side
    output logic                        s0_waitrequest,
    output logic [DATA_WIDTH-1:0]       s0_readdata,
    output logic                        s0_readdatavalid,
    output logic [RESPONSE_WIDTH-1:0]   s0_response,
    input  logic [BURSTCOUNT_WIDTH-1:0] s0_burstcount,
    input  logic [DATA_WIDTH-1:0]       s0_writedata,
    input  logic [HDL_ADDR_WIDTH-1:0]   s0_address,
    input  logic                        s0_write,
    input  logic                        s0_read,
    input  logic [BYTEENABLE_WIDTH-1:0] s0_byteenable,
    input  logic                        s0_debugaccess,
    // master side
    input  logic                        m0_waitrequest,
    input  logic [DATA_WIDTH-1:0]       m0_readdata,
    input  logic                        m0_readdatavalid,
    input  logic [RESPONSE_WIDTH-1:0]   m0_response,
    output logic [BURSTCOUNT_WIDTH-1:0] m0_burstcount,
    output logic [DATA_WIDTH-1:0]       m0_writedata,
    output logic [HDL_ADDR_WIDTH-1:0]   m0_address,
    output logic                        m0_write,
    output logic                        m0_read,
    output logic [BYTEENABLE_WIDTH-1:0] m0_byteenable,
    output logic                        m0_debugaccess
);

    typedef struct packed {
        logic                        read;
        logic                        write;
        logic [HDL_ADDR_WIDTH-1:0]   address;
        logic [BURSTCOUNT_WIDTH-1:0] burstcount;
        logic [DATA_WIDTH-1:0]       writedata;
        logic [BYTEENABLE_WIDTH-1:0] byteenable;
        logic                        debugaccess;
    } cmd_t;

    cmd_t s0_cmd;
    cmd_t out_q, out_d;
    cmd_t skid_q, skid_d;
    logic skid_full_q, skid_full_d;
    logic wait_q;
    logic s0_accept;
    logic out_busy;
    logic out_free;

    assign s0_cmd = '{
        read:        s0_read,
        write:       s0_write,
        address:     s0_address,
        burstcount:  s0_burstcount,
        writedata:   s0_writedata,
        byteenable:  s0_byteenable,
        debugaccess: s0_debugaccess
    };

    // wait_q tracks skid_full, so an accept can only happen while the skid is empty.
    assign s0_accept = (s0_read | s0_write) & ~wait_q;
    assign out_busy  = out_q.read | out_q.write;
    // Output register can take a new command when empty or when its current one transfers.
    assign out_free  = ~out_busy | ~m0_waitrequest;

    always_comb begin
        out_d       = out_q;
        skid_d      = skid_q;
        skid_full_d = skid_full_q;
        if (out_free) begin
            if (skid_full_q) begin
                out_d       = skid_q;
                skid_full_d = 1'b0;
            end else if (s0_accept) begin
                out_d = s0_cmd;
            end else begin
                // Idle: drop the strobes, keep the last fields on the bus.
                out_d.read  = 1'b0;
                out_d.write = 1'b0;
            end
        end else if (s0_accept) begin
            skid_d      = s0_cmd;
            skid_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q       <= '0;
            skid_q      <= '0;
            skid_full_q <= 1'b0;
            wait_q      <= 1'b1;
        end else begin
            out_q       <= out_d;
            skid_q      <= skid_d;
            skid_full_q <= skid_full_d;
            wait_q      <= skid_full_d;
        end
    end

    assign s0_waitrequest = wait_q;
    assign m0_read        = out_q.read;
    assign m0_write       = out_q.write;
    assign m0_address     = out_q.address;
    assign m0_burstcount  = out_q.burstcount;
    assign m0_writedata   = out_q.writedata;
    assign m0_byteenable  = out_q.byteenable;
    assign m0_debugaccess = out_q.debugaccess;

    // Response path: plain register stage; data/response only captured with valid
    // so an undefined m0_response between beats never reaches s0.
    logic                      rdv_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic [RESPONSE_WIDTH-1:0] resp_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdv_q   <= 1'b0;
            rdata_q <= '0;
            resp_q  <= '0;
        end else begin
            rdv_q <= m0_readdatavalid;
            if (m0_readdatavalid) begin
                rdata_q <= m0_readdata;
                resp_q  <= m0_response;
            end
        end
    end

    assign s0_readdatavalid = rdv_q;
    assign s0_readdata      = rdata_q;
    assign s0_response      = resp_q;

endmodule

// File: tb/tb_avmm_pipeline_bridge.sv
module tb_avmm_pipeline_bridge;

    localparam int DW  = 512;
    localparam int AW  = 27;
    localparam int BW  = 7;
    localparam int BEW = DW / 8;
    localparam int RW  = 2;

    logic           clk;
    logic           reset_n;
    logic           s0_waitrequest;
    logic [DW-1:0]  s0_readdata;
    logic           s0_readdatavalid;
    logic [RW-1:0]  s0_response;
    logic [BW-1:0]  s0_burstcount;
    logic [DW-1:0]  s0_writedata;
    logic [AW-1:0]  s0_address;
    logic           s0_write;
    logic           s0_read;
    logic [BEW-1:0] s0_byteenable;
    logic           s0_debugaccess;
    logic           m0_waitrequest;
    logic [DW-1:0]  m0_readdata;
    logic           m0_readdatavalid;
    logic [RW-1:0]  m0_response;
    logic [BW-1:0]  m0_burstcount;
    logic [DW-1:0]  m0_writedata;
    logic [AW-1:0]  m0_address;
    logic           m0_write;
    logic           m0_read;
    logic [BEW-1:0] m0_byteenable;
    logic           m0_debugaccess;

    int n_checks = 0;
    int n_fail   = 0;

    avmm_pipeline_bridge #(
        .DATA_WIDTH      (DW),
        .HDL_ADDR_WIDTH  (AW),
        .BURSTCOUNT_WIDTH(BW),
        .BYTEENABLE_WIDTH(BEW),
        .RESPONSE_WIDTH  (RW)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .s0_waitrequest  (s0_waitrequest),
        .s0_readdata     (s0_readdata),
        .s0_readdatavalid(s0_readdatavalid),
        .s0_response     (s0_response),
        .s0_burstcount   (s0_burstcount),
        .s0_writedata    (s0_writedata),
        .s0_address      (s0_address),
        .s0_write        (s0_write),
        .s0_read         (s0_read),
        .s0_byteenable   (s0_byteenable),
        .s0_debugaccess  (s0_debugaccess),
        .m0_waitrequest  (m0_waitrequest),
        .m0_readdata     (m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m0_response     (m0_response),
        .m0_burstcount   (m0_burstcount),
        .m0_writedata    (m0_writedata),
        .m0_address      (m0_address),
        .m0_write        (m0_write),
        .m0_read         (m0_read),
        .m0_byteenable   (m0_byteenable),
        .m0_debugaccess  (m0_debugaccess)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_write(input logic [AW-1:0] a, input logic [BW-1:0] bc, input logic [DW-1:0] d);
        s0_write      = 1'b1;
        s0_read       = 1'b0;
        s0_address    = a;
        s0_burstcount = bc;
        s0_writedata  = d;
        s0_byteenable = '1;
    endtask

    logic [DW-1:0] pat_a5;

    initial begin
        pat_a5           = {(DW/8){8'hA5}};
        reset_n          = 1'b0;
        s0_burstcount    = '0;
        s0_writedata     = '0;
        s0_address       = '0;
        s0_write         = 1'b0;
        s0_read          = 1'b0;
        s0_byteenable    = '0;
        s0_debugaccess   = 1'b0;
        m0_waitrequest   = 1'b0;
        m0_readdata      = '0;
        m0_readdatavalid = 1'b0;
        m0_response      = '0;

        // ---- reset then idle ----
        repeat (5) step();
        chk("rst_waitrequest", DW'(s0_waitrequest), DW'(1'b1));
        chk("rst_m0_read", DW'(m0_read), DW'(1'b0));
        chk("rst_m0_write", DW'(m0_write), DW'(1'b0));
        chk("rst_s0_rdv", DW'(s0_readdatavalid), DW'(1'b0));
        chk("rst_m0_address", DW'(m0_address), DW'(0));
        reset_n = 1'b1;
        step();
        chk("post_rst_waitrequest", DW'(s0_waitrequest), DW'(1'b0));

        // ---- single write ----
        drive_write(27'h10, 7'd1, pat_a5);
        s0_debugaccess = 1'b1;
        step();
        s0_write       = 1'b0;
        s0_debugaccess = 1'b0;
        chk("sw_m0_write", DW'(m0_write), DW'(1'b1));
        chk("sw_m0_read", DW'(m0_read), DW'(1'b0));
        chk("sw_m0_address", DW'(m0_address), DW'(27'h10));
        chk("sw_m0_burstcount", DW'(m0_burstcount), DW'(7'd1));
        chk("sw_m0_writedata", m0_writedata, pat_a5);
        chk("sw_m0_byteenable", DW'(m0_byteenable), DW'({BEW{1'b1}}));
        chk("sw_m0_debugaccess", DW'(m0_debugaccess), DW'(1'b1));
        step();
        chk("sw_m0_write_drop", DW'(m0_write), DW'(1'b0));

        // ---- back-to-back writes with a 3-cycle stall ----
        m0_waitrequest = 1'b1;
        drive_write(27'h40, 7'd4, DW'(1));
        step();                                   // beat 1 into output register
        chk("bb_b1_data", m0_writedata, DW'(1));
        chk("bb_b1_wait", DW'(s0_waitrequest), DW'(1'b0));
        drive_write(27'h40, 7'd4, DW'(2));
        step();                                   // beat 2 into skid
        chk("bb_wait_rise", DW'(s0_waitrequest), DW'(1'b1));
        chk("bb_b1_hold", m0_writedata, DW'(1));
        chk("bb_b1_hold_wr", DW'(m0_write), DW'(1'b1));
        drive_write(27'h40, 7'd4, DW'(3));        // held by upstream: waitrequest is high
        step();
        chk("bb_wait_hold", DW'(s0_waitrequest), DW'(1'b1));
        chk("bb_b1_hold2", m0_writedata, DW'(1));
        m0_waitrequest = 1'b0;
        step();                                   // beat 1 transfers, skid -> output
        chk("bb_b2_data", m0_writedata, DW'(2));
        chk("bb_wait_fall", DW'(s0_waitrequest), DW'(1'b0));
        step();                                   // beat 2 transfers, beat 3 accepted
        chk("bb_b3_data", m0_writedata, DW'(3));
        chk("bb_b3_wr", DW'(m0_write), DW'(1'b1));
        drive_write(27'h40, 7'd4, DW'(4));
        step();
        s0_write = 1'b0;
        chk("bb_b4_data", m0_writedata, DW'(4));
        chk("bb_b4_addr", DW'(m0_address), DW'(27'h40));
        chk("bb_b4_bc", DW'(m0_burstcount), DW'(7'd4));
        step();
        chk("bb_done_wr", DW'(m0_write), DW'(1'b0));

        // ---- read with 2-beat response ----
        s0_read       = 1'b1;
        s0_address    = 27'h100;
        s0_burstcount = 7'd2;
        step();
        s0_read = 1'b0;
        chk("rd_m0_read", DW'(m0_read), DW'(1'b1));
        chk("rd_m0_address", DW'(m0_address), DW'(27'h100));
        chk("rd_m0_bc", DW'(m0_burstcount), DW'(7'd2));
        step();
        chk("rd_m0_read_drop", DW'(m0_read), DW'(1'b0));
        m0_readdatavalid = 1'b1;
        m0_readdata      = DW'(8'h11);
        m0_response      = 2'b00;
        chk("rd_no_early_rdv", DW'(s0_readdatavalid), DW'(1'b0));
        step();
        m0_readdata = DW'(8'h22);
        m0_response = 2'b01;
        chk("rd_beat1_rdv", DW'(s0_readdatavalid), DW'(1'b1));
        chk("rd_beat1_data", s0_readdata, DW'(8'h11));
        step();
        m0_readdatavalid = 1'b0;
        m0_readdata      = DW'(8'hFF);
        m0_response      = 2'bxx;
        chk("rd_beat2_rdv", DW'(s0_readdatavalid), DW'(1'b1));
        chk("rd_beat2_data", s0_readdata, DW'(8'h22));
        chk("rd_beat2_resp", DW'(s0_response), DW'(2'b01));
        step();
        chk("rd_rdv_drop", DW'(s0_readdatavalid), DW'(1'b0));
        chk("rd_data_hold", s0_readdata, DW'(8'h22));
        chk("rd_resp_hold", DW'(s0_response), DW'(2'b01));
        m0_response = 2'b00;

        // ---- 16 back-to-back single reads ----
        s0_burstcount = 7'd1;
        for (int i = 0; i < 16; i++) begin
            s0_read    = 1'b1;
            s0_address = AW'(i + 27'h200);
            step();
            chk("tp_m0_read", DW'(m0_read), DW'(1'b1));
            chk("tp_m0_address", DW'(m0_address), DW'(i + 27'h200));
            chk("tp_wait", DW'(s0_waitrequest), DW'(1'b0));
        end
        s0_read = 1'b0;
        step();
        chk("tp_m0_read_drop", DW'(m0_read), DW'(1'b0));

        // ---- reset while a command sits in skid ----
        m0_waitrequest = 1'b1;
        drive_write(27'h300, 7'd2, DW'(7));
        step();
        drive_write(27'h300, 7'd2, DW'(8));
        m0_readdatavalid = 1'b1;
        m0_readdata      = DW'(8'h33);
        step();
        s0_write = 1'b0;
        chk("mr_skid_wait", DW'(s0_waitrequest), DW'(1'b1));
        chk("mr_rdv_before", DW'(s0_readdatavalid), DW'(1'b1));
        #2;
        reset_n = 1'b0;
        #1;
        chk("mr_m0_write", DW'(m0_write), DW'(1'b0));
        chk("mr_m0_read", DW'(m0_read), DW'(1'b0));
        chk("mr_s0_rdv", DW'(s0_readdatavalid), DW'(1'b0));
        chk("mr_wait", DW'(s0_waitrequest), DW'(1'b1));
        chk("mr_readdata", s0_readdata, DW'(0));
        m0_waitrequest   = 1'b0;
        m0_readdatavalid = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        chk("mr_post_wait", DW'(s0_waitrequest), DW'(1'b0));
        chk("mr_post_write", DW'(m0_write), DW'(1'b0));
        step();
        chk("mr_skid_gone", DW'(m0_write), DW'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
